// File: rtl/mpi_arbiter.sv
// mpi_arbiter: round-robin arbiter that lets two requesters share one
// microprocessor-interface (MPI) bus. Each transaction runs
// IDLE -> SETUP -> ACCESS -> DONE. ACCESS waits for an active-low ready,
// or gives up with an error after TIMEOUT_CYC cycles.
module mpi_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic        clk_100m,
    input  logic        rst,

    input  logic        req0,
    input  logic        we0,
    input  logic [15:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    output logic [31:0] rdata0,
    output logic        err0,

    input  logic        req1,
    input  logic        we1,
    input  logic [15:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic [31:0] rdata1,
    output logic        err1,

    output logic        busy,

    output logic        cpu_cs_n,
    output logic        cpu_rd_n,
    output logic        cpu_we_n,
    output logic [15:0] cpu_addr,
    output logic [31:0] cpu_data_o,
    output logic        cpu_data_oe,
    input  logic [31:0] cpu_data_i,
    input  logic        cpu_rdy_n
);

    // Value the wait counter holds in the final permitted ACCESS cycle.
    localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StDone
    } state_e;

    state_e      state_q;
    logic        owner_q;       // 0 = requester 0, 1 = requester 1
    logic        last_grant_q;  // owner of the most recently finished transaction
    logic        we_q;          // latched direction of the current transaction
    logic [7:0]  wait_cnt_q;    // ACCESS cycles already spent, starting at 0

    logic        grant_id;
    logic        access_end;

    // Round-robin pick: on a tie the requester not served last wins.
    always_comb begin
        if (req0 && req1) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1;
        end
    end

    // ACCESS finishes on ready; ready in the last counted cycle beats the timeout.
    assign access_end = !cpu_rdy_n || (wait_cnt_q == WaitLast);

    assign busy = (state_q != StIdle);

    // Transaction FSM with registered MPI strobes and requester responses.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            wait_cnt_q   <= 8'd0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            rdata0       <= 32'd0;
            rdata1       <= 32'd0;
            cpu_cs_n     <= 1'b1;
            cpu_rd_n     <= 1'b1;
            cpu_we_n     <= 1'b1;
            cpu_addr     <= 16'd0;
            cpu_data_o   <= 32'd0;
            cpu_data_oe  <= 1'b0;
        end else begin
            // Acks are single-cycle strobes; only the ACCESS exit raises one.
            ack0 <= 1'b0;
            ack1 <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        owner_q     <= grant_id;
                        we_q        <= grant_id ? we1 : we0;
                        cpu_addr    <= grant_id ? addr1 : addr0;
                        cpu_data_o  <= grant_id ? wdata1 : wdata0;
                        cpu_data_oe <= grant_id ? we1 : we0;
                        cpu_cs_n    <= 1'b0;
                        cpu_rd_n    <= 1'b1;
                        cpu_we_n    <= 1'b1;
                        state_q     <= StSetup;
                    end
                end

                StSetup: begin
                    cpu_rd_n   <= we_q;
                    cpu_we_n   <= ~we_q;
                    wait_cnt_q <= 8'd0;
                    state_q    <= StAccess;
                end

                StAccess: begin
                    if (access_end) begin
                        cpu_cs_n    <= 1'b1;
                        cpu_rd_n    <= 1'b1;
                        cpu_we_n    <= 1'b1;
                        cpu_data_oe <= 1'b0;
                        state_q     <= StDone;
                        // cpu_rdy_n still high here means the timeout fired.
                        if (owner_q) begin
                            ack1 <= 1'b1;
                            err1 <= cpu_rdy_n;
                            if (!cpu_rdy_n && !we_q) begin
                                rdata1 <= cpu_data_i;
                            end
                        end else begin
                            ack0 <= 1'b1;
                            err0 <= cpu_rdy_n;
                            if (!cpu_rdy_n && !we_q) begin
                                rdata0 <= cpu_data_i;
                            end
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end

                StDone: begin
                    last_grant_q <= owner_q;
                    state_q      <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpi_arbiter.sv
// tb_mpi_arbiter: directed and randomized checks of mpi_arbiter against a
// transaction-level model (who wins, how long ACCESS lasts, err and rdata).
module tb_mpi_arbiter;

    localparam int TO = 64;

    logic        clk_100m;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1, err0, err1, busy;
    logic [31:0] rdata0, rdata1;
    logic        cpu_cs_n, cpu_rd_n, cpu_we_n, cpu_data_oe, cpu_rdy_n;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_data_o, cpu_data_i;

    int n_checks = 0;
    int n_errors = 0;

    mpi_arbiter #(.TIMEOUT_CYC(TO)) dut (
        .clk_100m    (clk_100m),
        .rst         (rst),
        .req0        (req0),
        .we0         (we0),
        .addr0       (addr0),
        .wdata0      (wdata0),
        .ack0        (ack0),
        .rdata0      (rdata0),
        .err0        (err0),
        .req1        (req1),
        .we1         (we1),
        .addr1       (addr1),
        .wdata1      (wdata1),
        .ack1        (ack1),
        .rdata1      (rdata1),
        .err1        (err1),
        .busy        (busy),
        .cpu_cs_n    (cpu_cs_n),
        .cpu_rd_n    (cpu_rd_n),
        .cpu_we_n    (cpu_we_n),
        .cpu_addr    (cpu_addr),
        .cpu_data_o  (cpu_data_o),
        .cpu_data_oe (cpu_data_oe),
        .cpu_data_i  (cpu_data_i),
        .cpu_rdy_n   (cpu_rdy_n)
    );

    initial clk_100m = 1'b0;
    always #5 clk_100m = ~clk_100m;

    // ---------------- transaction-level reference model ----------------
    int          m_last;
    logic [31:0] m_rdata [2];

    task automatic m_reset();
        m_last     = 1;
        m_rdata[0] = 32'd0;
        m_rdata[1] = 32'd0;
    endtask

    function automatic int m_winner(input bit r0, input bit r1);
        if (r0 && r1) return 1 - m_last;
        return r1 ? 1 : 0;
    endfunction

    // Number of ACCESS cycles for a ready arriving on ACCESS cycle rdy_at (0 = never).
    function automatic int m_acc(input int rdy_at);
        return (rdy_at >= 1 && rdy_at <= TO) ? rdy_at : TO;
    endfunction

    function automatic bit m_err(input int rdy_at);
        return !(rdy_at >= 1 && rdy_at <= TO);
    endfunction

    task automatic m_complete(input int w, input bit we, input int rdy_at, input logic [31:0] d);
        m_last = w;
        if (!we && !m_err(rdy_at)) m_rdata[w] = d;
    endtask

    // ---------------- bus observer / ready responder ----------------
    bit          obs_ok, obs_held, obs_overlap, obs_busy_ok;
    int          obs_cycles, obs_idle, obs_setup, obs_acc, obs_rd_low, obs_we_low;
    logic [15:0] obs_setup_addr;
    logic [31:0] obs_setup_data;
    logic        obs_setup_oe;
    logic        obs_ack0, obs_ack1, obs_err0, obs_err1, obs_done_busy;
    logic [31:0] obs_rdata0, obs_rdata1;
    logic [3:0]  obs_done_pins;

    // Follows one transaction until an ack, answering ready on ACCESS cycle rdy_at.
    task automatic observe_txn(input int rdy_at, input logic [31:0] rd_word, input bit scramble);
        obs_ok = 0; obs_held = 1; obs_overlap = 0; obs_busy_ok = 1;
        obs_cycles = 0; obs_idle = 0; obs_setup = 0; obs_acc = 0;
        obs_rd_low = 0; obs_we_low = 0;
        obs_setup_addr = '0; obs_setup_data = '0; obs_setup_oe = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk_100m); #1;
            obs_cycles++;
            if (scramble) begin
                we0 = 1'($urandom); we1 = 1'($urandom);
                addr0 = 16'($urandom); addr1 = 16'($urandom);
                wdata0 = $urandom; wdata1 = $urandom;
            end
            if (ack0 && ack1) obs_overlap = 1;
            if (ack0 || ack1) begin
                obs_ok = 1;
                obs_ack0 = ack0; obs_ack1 = ack1;
                obs_err0 = err0; obs_err1 = err1;
                obs_rdata0 = rdata0; obs_rdata1 = rdata1;
                obs_done_pins = {cpu_cs_n, cpu_rd_n, cpu_we_n, cpu_data_oe};
                obs_done_busy = busy;
                cpu_rdy_n = 1'b1;
                break;
            end
            if (cpu_cs_n) begin
                obs_idle++;
                if (busy) obs_busy_ok = 0;
                cpu_rdy_n = 1'($urandom);
            end else if (cpu_rd_n && cpu_we_n) begin
                obs_setup++;
                if (!busy) obs_busy_ok = 0;
                obs_setup_addr = cpu_addr;
                obs_setup_data = cpu_data_o;
                obs_setup_oe = cpu_data_oe;
                cpu_rdy_n = 1'($urandom);
            end else begin
                obs_acc++;
                if (!busy) obs_busy_ok = 0;
                if (!cpu_rd_n) obs_rd_low++;
                if (!cpu_we_n) obs_we_low++;
                if (cpu_addr !== obs_setup_addr || cpu_data_o !== obs_setup_data ||
                    cpu_data_oe !== obs_setup_oe) obs_held = 0;
                if (obs_acc == rdy_at) begin
                    cpu_rdy_n = 1'b0;
                    cpu_data_i = rd_word;
                end else begin
                    cpu_rdy_n = 1'b1;
                    cpu_data_i = $urandom;
                end
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk_100m); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk_100m);
        #1;
        m_reset();
        n_checks++;
        if ({cpu_cs_n, cpu_rd_n, cpu_we_n, cpu_data_oe} !== 4'b1110) begin
            n_errors++;
            $display("FAIL reset_strobes: got %b, expected 1110",
                     {cpu_cs_n, cpu_rd_n, cpu_we_n, cpu_data_oe});
        end
        n_checks++;
        if (cpu_addr !== 16'd0 || cpu_data_o !== 32'd0) begin
            n_errors++;
            $display("FAIL reset_bus: got addr %h data %h, expected 0 0", cpu_addr, cpu_data_o);
        end
        n_checks++;
        if ({ack0, ack1, err0, err1, busy} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_flags: got %b, expected 00000", {ack0, ack1, err0, err1, busy});
        end
        n_checks++;
        if (rdata0 !== m_rdata[0] || rdata1 !== m_rdata[1]) begin
            n_errors++;
            $display("FAIL reset_rdata: got %h %h, expected %h %h",
                     rdata0, rdata1, m_rdata[0], m_rdata[1]);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        idle_cycle();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010; wdata0 = $urandom;
        observe_txn(2, 32'hDEADBEEF, 1'b0);
        req0 = 1'b0;
        m_complete(m_winner(1, 0), 1'b0, 2, 32'hDEADBEEF);
        n_checks++;
        if (!obs_ok || {obs_ack1, obs_ack0} !== 2'b01) begin
            n_errors++;
            $display("FAIL read_owner: got ok=%0d acks=%b, expected ok=1 acks=01",
                     obs_ok, {obs_ack1, obs_ack0});
        end
        n_checks++;
        if (obs_rd_low != 2 || obs_we_low != 0) begin
            n_errors++;
            $display("FAIL read_strobes: got rd_low=%0d we_low=%0d, expected 2 0",
                     obs_rd_low, obs_we_low);
        end
        n_checks++;
        if (obs_setup != 1 || obs_setup_addr !== 16'h0010 || obs_setup_oe !== 1'b0) begin
            n_errors++;
            $display("FAIL read_setup: got n=%0d addr=%h oe=%b, expected 1 0010 0",
                     obs_setup, obs_setup_addr, obs_setup_oe);
        end
        n_checks++;
        if (obs_rdata0 !== m_rdata[0] || obs_err0 !== 1'b0) begin
            n_errors++;
            $display("FAIL read_data: got %h err=%b, expected %h err=0",
                     obs_rdata0, obs_err0, m_rdata[0]);
        end
        n_checks++;
        if (obs_done_pins !== 4'b1110 || obs_done_busy !== 1'b1) begin
            n_errors++;
            $display("FAIL read_done_pins: got %b busy=%b, expected 1110 busy=1",
                     obs_done_pins, obs_done_busy);
        end
        n_checks++;
        if (obs_cycles != 4) begin
            n_errors++;
            $display("FAIL read_latency: got %0d, expected 4", obs_cycles);
        end
        idle_cycle();
        n_checks++;
        if (ack0 !== 1'b0 || rdata0 !== m_rdata[0] || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL read_after_ack: got ack0=%b rdata0=%h busy=%b, expected 0 %h 0",
                     ack0, rdata0, busy, m_rdata[0]);
        end
    endtask

    task automatic test_single_write();
        idle_cycle();
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h00A4; wdata1 = 32'h12345678;
        observe_txn(1, $urandom, 1'b0);
        req1 = 1'b0;
        m_complete(m_winner(0, 1), 1'b1, 1, 32'd0);
        n_checks++;
        if (!obs_ok || {obs_ack1, obs_ack0} !== 2'b10 || obs_err1 !== 1'b0) begin
            n_errors++;
            $display("FAIL write_ack: got ok=%0d acks=%b err1=%b, expected 1 10 0",
                     obs_ok, {obs_ack1, obs_ack0}, obs_err1);
        end
        n_checks++;
        if (obs_setup_oe !== 1'b1 || !obs_held || obs_setup_data !== 32'h12345678) begin
            n_errors++;
            $display("FAIL write_drive: got oe=%b held=%0d data=%h, expected 1 1 12345678",
                     obs_setup_oe, obs_held, obs_setup_data);
        end
        n_checks++;
        if (obs_we_low != 1 || obs_rd_low != 0) begin
            n_errors++;
            $display("FAIL write_strobes: got we_low=%0d rd_low=%0d, expected 1 0",
                     obs_we_low, obs_rd_low);
        end
        n_checks++;
        if (obs_cycles + 1 != 4) begin
            n_errors++;
            $display("FAIL write_latency: got %0d, expected 4", obs_cycles + 1);
        end
        n_checks++;
        if (obs_rdata1 !== m_rdata[1]) begin
            n_errors++;
            $display("FAIL write_rdata_kept: got %h, expected %h", obs_rdata1, m_rdata[1]);
        end
    endtask

    task automatic test_contention();
        int          order [4];
        int          w;
        int          rdy_at;
        logic [31:0] d;
        order = '{0, 1, 0, 1};
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        m_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0100; wdata0 = $urandom;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0200; wdata1 = $urandom;
        for (int k = 0; k < 4; k++) begin
            rdy_at = int'($urandom_range(1, 3));
            d = $urandom;
            observe_txn(rdy_at, d, 1'b0);
            w = m_winner(1, 1);
            m_complete(w, (w == 1), rdy_at, d);
            n_checks++;
            if (!obs_ok || w != order[k] || {obs_ack1, obs_ack0} !== (w == 1 ? 2'b10 : 2'b01)) begin
                n_errors++;
                $display("FAIL contention_order[%0d]: got acks=%b, expected owner %0d",
                         k, {obs_ack1, obs_ack0}, order[k]);
            end
            n_checks++;
            if (obs_overlap || obs_idle != (k == 0 ? 0 : 1) || !obs_busy_ok) begin
                n_errors++;
                $display("FAIL contention_gap[%0d]: got overlap=%0d idle=%0d busy_ok=%0d, expected 0 %0d 1",
                         k, obs_overlap, obs_idle, obs_busy_ok, (k == 0 ? 0 : 1));
            end
            n_checks++;
            if (obs_acc != m_acc(rdy_at) || obs_rdata0 !== m_rdata[0]) begin
                n_errors++;
                $display("FAIL contention_access[%0d]: got acc=%0d rdata0=%h, expected %0d %h",
                         k, obs_acc, obs_rdata0, m_acc(rdy_at), m_rdata[0]);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_timeout(input int who, input int rdy_at);
        logic [31:0] d;
        logic        e;
        logic [31:0] r;
        d = $urandom;
        idle_cycle();
        if (who == 0) begin req0 = 1'b1; we0 = 1'b0; addr0 = 16'($urandom); end
        else          begin req1 = 1'b1; we1 = 1'b0; addr1 = 16'($urandom); end
        observe_txn(rdy_at, d, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        m_complete(who, 1'b0, rdy_at, d);
        e = (who == 0) ? obs_err0 : obs_err1;
        r = (who == 0) ? obs_rdata0 : obs_rdata1;
        n_checks++;
        if (!obs_ok || obs_acc != m_acc(rdy_at) || obs_rd_low != m_acc(rdy_at)) begin
            n_errors++;
            $display("FAIL timeout_len(rdy_at=%0d): got ok=%0d acc=%0d rd_low=%0d, expected 1 %0d",
                     rdy_at, obs_ok, obs_acc, obs_rd_low, m_acc(rdy_at));
        end
        n_checks++;
        if (e !== 1'(m_err(rdy_at)) || r !== m_rdata[who]) begin
            n_errors++;
            $display("FAIL timeout_result(rdy_at=%0d): got err=%b rdata=%h, expected %0d %h",
                     rdy_at, e, r, m_err(rdy_at), m_rdata[who]);
        end
    endtask

    task automatic test_ignore_midflight();
        idle_cycle();
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h5A5A; wdata0 = 32'hCAFEF00D;
        observe_txn(3, $urandom, 1'b1);
        req0 = 1'b0;
        m_complete(m_winner(1, 0), 1'b1, 3, 32'd0);
        n_checks++;
        if (obs_setup_addr !== 16'h5A5A || obs_setup_data !== 32'hCAFEF00D || !obs_held) begin
            n_errors++;
            $display("FAIL midflight_hold: got addr=%h data=%h held=%0d, expected 5a5a cafef00d 1",
                     obs_setup_addr, obs_setup_data, obs_held);
        end
        n_checks++;
        if (obs_we_low != 3 || obs_rd_low != 0 || {obs_ack1, obs_ack0} !== 2'b01) begin
            n_errors++;
            $display("FAIL midflight_dir: got we_low=%0d rd_low=%0d acks=%b, expected 3 0 01",
                     obs_we_low, obs_rd_low, {obs_ack1, obs_ack0});
        end
    endtask

    task automatic test_reset_mid_access();
        int          acc;
        bit          hit;
        bit          stray_ack;
        logic [31:0] d;
        d = $urandom;
        idle_cycle();
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
        observe_txn(1, d, 1'b0);
        req0 = 1'b0;
        m_complete(0, 1'b0, 1, d);
        idle_cycle();
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0077; wdata0 = $urandom;
        acc = 0;
        hit = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk_100m); #1;
            cpu_rdy_n = 1'b1;
            if (!cpu_cs_n && (!cpu_rd_n || !cpu_we_n)) acc++;
            if (acc == 3) begin
                rst = 1'b1;
                hit = 1;
                break;
            end
        end
        req0 = 1'b0;
        n_checks++;
        if (!hit) begin
            n_errors++;
            $display("FAIL midreset_reach: got no 3rd ACCESS cycle, expected one");
        end
        idle_cycle();
        rst = 1'b0;
        m_reset();
        n_checks++;
        if ({cpu_cs_n, cpu_rd_n, cpu_we_n, cpu_data_oe} !== 4'b1110 ||
            cpu_addr !== 16'd0 || cpu_data_o !== 32'd0) begin
            n_errors++;
            $display("FAIL midreset_bus: got %b addr=%h data=%h, expected 1110 0 0",
                     {cpu_cs_n, cpu_rd_n, cpu_we_n, cpu_data_oe}, cpu_addr, cpu_data_o);
        end
        n_checks++;
        if ({ack0, ack1, err0, err1, busy} !== 5'b0 || rdata0 !== m_rdata[0]) begin
            n_errors++;
            $display("FAIL midreset_flags: got %b rdata0=%h, expected 00000 %h",
                     {ack0, ack1, err0, err1, busy}, rdata0, m_rdata[0]);
        end
        stray_ack = 0;
        repeat (3) begin
            idle_cycle();
            if (ack0 || ack1) stray_ack = 1;
        end
        n_checks++;
        if (stray_ack) begin
            n_errors++;
            $display("FAIL midreset_no_ack: got an ack, expected none");
        end
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0001;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0002;
        d = $urandom;
        observe_txn(1, d, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        n_checks++;
        if ({obs_ack1, obs_ack0} !== (m_winner(1, 1) == 1 ? 2'b10 : 2'b01)) begin
            n_errors++;
            $display("FAIL midreset_priority: got acks=%b, expected owner %0d",
                     {obs_ack1, obs_ack0}, m_winner(1, 1));
        end
        m_complete(m_winner(1, 1), 1'b0, 1, d);
    endtask

    task automatic test_random();
        int          w, rdy_at, sel;
        bit          r0, r1, sc;
        logic        w0, w1, wwe;
        logic [15:0] a0, a1;
        logic [31:0] d0, d1, rw, own_r, oth_r;
        logic        own_e;
        for (int it = 0; it < 40; it++) begin
            idle_cycle();
            sel = int'($urandom_range(1, 3));
            r0 = sel[0]; r1 = sel[1];
            w0 = 1'($urandom); w1 = 1'($urandom);
            a0 = 16'($urandom); a1 = 16'($urandom);
            d0 = $urandom; d1 = $urandom; rw = $urandom;
            sel = int'($urandom_range(0, 9));
            rdy_at = (sel == 0) ? 0 : (sel == 1) ? TO : int'($urandom_range(1, 5));
            sc = 1'($urandom);
            req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
            req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
            observe_txn(rdy_at, rw, sc);
            req0 = 1'b0; req1 = 1'b0;
            w = m_winner(r0, r1);
            wwe = (w == 1) ? w1 : w0;
            m_complete(w, wwe, rdy_at, rw);
            own_r = (w == 1) ? obs_rdata1 : obs_rdata0;
            oth_r = (w == 1) ? obs_rdata0 : obs_rdata1;
            own_e = (w == 1) ? obs_err1 : obs_err0;
            n_checks++;
            if (!obs_ok || {obs_ack1, obs_ack0} !== (w == 1 ? 2'b10 : 2'b01)) begin
                n_errors++;
                $display("FAIL rand_owner[%0d]: got ok=%0d acks=%b, expected owner %0d",
                         it, obs_ok, {obs_ack1, obs_ack0}, w);
            end
            n_checks++;
            if (obs_acc != m_acc(rdy_at) || obs_cycles != m_acc(rdy_at) + 2 || obs_setup != 1) begin
                n_errors++;
                $display("FAIL rand_timing[%0d]: got acc=%0d cycles=%0d setup=%0d, expected %0d %0d 1",
                         it, obs_acc, obs_cycles, obs_setup, m_acc(rdy_at), m_acc(rdy_at) + 2);
            end
            n_checks++;
            if (own_e !== 1'(m_err(rdy_at)) || own_r !== m_rdata[w] || oth_r !== m_rdata[1 - w]) begin
                n_errors++;
                $display("FAIL rand_result[%0d]: got err=%b own=%h other=%h, expected %0d %h %h",
                         it, own_e, own_r, oth_r, m_err(rdy_at), m_rdata[w], m_rdata[1 - w]);
            end
            n_checks++;
            if (obs_setup_addr !== ((w == 1) ? a1 : a0) || obs_setup_oe !== wwe || !obs_held ||
                (wwe && obs_setup_data !== ((w == 1) ? d1 : d0))) begin
                n_errors++;
                $display("FAIL rand_bus[%0d]: got addr=%h oe=%b held=%0d data=%h, expected %h %b 1",
                         it, obs_setup_addr, obs_setup_oe, obs_held, obs_setup_data,
                         (w == 1) ? a1 : a0, wwe);
            end
            n_checks++;
            if (obs_rd_low != (wwe ? 0 : m_acc(rdy_at)) || obs_we_low != (wwe ? m_acc(rdy_at) : 0) ||
                obs_done_pins !== 4'b1110) begin
                n_errors++;
                $display("FAIL rand_strobes[%0d]: got rd_low=%0d we_low=%0d done=%b, we=%b acc=%0d",
                         it, obs_rd_low, obs_we_low, obs_done_pins, wwe, m_acc(rdy_at));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        cpu_data_i = '0; cpu_rdy_n = 1'b1;
        m_reset();
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_timeout(0, 0);
        test_timeout(1, TO);
        test_ignore_midflight();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mpi_arbiter.md
MPI_ARBITER -- requirements
Module: mpi_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 64, giving the maximum ACCESS cycles to wait for cpu_rdy_n before aborting (legal range 2..255).
REQ-002 The block SHALL have port clk_100m, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have ports req0 / req1, input, 1 bit each: a transaction request from requester 0 / 1.
REQ-005 The block SHALL have ports we0 / we1, input, 1 bit each: 1 = write, 0 = read.
REQ-006 The block SHALL have ports addr0 / addr1, input, 16 bits each: the transaction address.
REQ-007 The block SHALL have ports wdata0 / wdata1, input, 32 bits each: the write data.
REQ-008 The block SHALL have ports ack0 / ack1, output, 1 bit each: a one-cycle completion strobe to the owning requester.
REQ-009 The block SHALL have ports rdata0 / rdata1, output, 32 bits each: read data, valid while the matching ack is high.
REQ-010 The block SHALL have ports err0 / err1, output, 1 bit each: timeout flag, valid while the matching ack is high.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 The block SHALL have ports cpu_cs_n, cpu_rd_n and cpu_we_n, output, 1 bit each: the active-low MPI strobes.
REQ-013 The block SHALL have port cpu_addr, output, 16 bits: the MPI address.
REQ-014 The block SHALL have ports cpu_data_o, output, 32 bits, and cpu_data_oe, output, 1 bit: MPI write data and its tristate enable (1 = drive).
REQ-015 The block SHALL have ports cpu_data_i, input, 32 bits, and cpu_rdy_n, input, 1 bit: MPI read data and the active-low ready.

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, ACCESS and DONE; all MPI outputs SHALL be registered or decoded only from registered state.
REQ-017 Requests SHALL be sampled only in IDLE; on any req high, the FSM SHALL latch the winner's we, addr and wdata plus the owner ID, then move to SETUP on the next edge.
REQ-018 Arbitration SHALL be round-robin: with both req high, the requester that was not last granted wins; with a single req high, that requester wins.
REQ-019 The last-granted register SHALL update in DONE.
REQ-020 SETUP SHALL last exactly 1 cycle with cpu_cs_n=0, cpu_rd_n=1, cpu_we_n=1, cpu_addr=latched address and cpu_data_oe=latched we, then move to ACCESS.
REQ-021 In ACCESS, cpu_cs_n SHALL be 0; a read SHALL have cpu_rd_n=0 and cpu_we_n=1, and a write SHALL have cpu_we_n=0 and cpu_rd_n=1.
REQ-022 In ACCESS, cpu_addr and cpu_data_o SHALL be held, cpu_data_oe SHALL equal we, and an 8-bit wait counter SHALL increment from 0 each cycle.
REQ-023 In ACCESS, cpu_rdy_n sampled 0 SHALL end the access: for a read, cpu_data_i is captured into the owner's rdata register; err is cleared; the next state is DONE.
REQ-024 In ACCESS, if the counter reaches TIMEOUT_CYC-1 with cpu_rdy_n still 1, the FSM SHALL move to DONE with err set and rdata unchanged.
REQ-025 A cpu_rdy_n=0 sample in that final cycle SHALL take priority over the timeout.
REQ-026 In DONE, the strobes SHALL be high and cpu_data_oe SHALL be 0; the owner's ack SHALL be high for exactly 1 cycle with its rdata/err valid, and the next state SHALL be IDLE.
REQ-027 The non-owner's ack SHALL remain 0.
REQ-028 Minimum transaction length SHALL be 4 cycles from the IDLE request-sample edge to the end of ack: IDLE, SETUP, 1×ACCESS, DONE.
REQ-029 A requester SHALL hold req and its request fields until it sees ack, and SHALL drop req in the cycle after ack unless it issues a new request.
REQ-030 A req still high in the IDLE that follows DONE SHALL be treated as a new request.
REQ-031 Request inputs SHALL be ignored outside IDLE; changing them mid-transaction SHALL NOT affect the latched transaction.
REQ-032 The rdata registers SHALL hold their value between acks.

Reset
REQ-033 On rst=1 at a clock edge, the block SHALL go to IDLE from any state, including mid-ACCESS, with no ack generated.
REQ-034 The reset values SHALL be: cpu_cs_n=1, cpu_rd_n=1, cpu_we_n=1, cpu_addr=0, cpu_data_o=0 and cpu_data_oe=0.
REQ-035 The reset values SHALL also be: ack0=ack1=0, err0=err1=0, rdata0=rdata1=0, busy=0, counter=0, and last-granted=1, so req1 loses the first tie and req0 wins it.

Verification
REQ-036 Single read: req0 with we0=0 and addr0=16'h0010, with cpu_rdy_n=0 on the 2nd ACCESS cycle and cpu_data_i=32'hDEADBEEF -> cpu_rd_n low for 2 cycles, then ack0 for 1 cycle with rdata0=32'hDEADBEEF and err0=0.
REQ-037 Single write: req1 with we1=1, addr1=16'h00A4 and wdata1=32'h12345678, with immediate rdy -> cpu_data_oe=1 in SETUP and ACCESS, cpu_we_n low for 1 cycle, ack1 with err1=0, and 4-cycle latency.
REQ-038 Contention: req0 and req1 raised together from reset and held -> grant order is 0,1,0,1, with no overlapping strobes and cs_n high for at least 1 cycle between transactions.
REQ-039 Timeout: cpu_rdy_n held at 1 with TIMEOUT_CYC=64 -> exactly 64 ACCESS cycles, then ack with err=1 and rdata unchanged.
REQ-040 Timeout boundary: rdy_n=0 on the 64th ACCESS cycle -> err=0 and the data is captured.
REQ-041 Reset mid-ACCESS: rst asserted on the 3rd ACCESS cycle -> all outputs at their reset values on the next edge, no ack, and the next request gives req0 priority.
